// File: rtl/indication_word_serializer.sv
// indication_word_serializer
//   Takes one 128-bit indication message plus its length (in 32-bit words)
//   and emits it as a stream of 32-bit words. An optional header word
//   {MSG_TAG, raw length} can be sent first. Back-to-back messages run with
//   no bubble, and the stream stalls under downstream backpressure.
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   in_enq__ENA/__RDY          message handshake (transfer when ENA & RDY)
//   in_enq_v, in_enq_length    payload (word k = v[32k+31:32k]) and length
//   out_enq__ENA/__RDY         word handshake (transfer when ENA & RDY)
//   out_enq_v, out_enq_last    output word, final-word marker
//   err_length                 sticky: a message with length > 4 was accepted
//   msg_count                  completed messages (wraps at 2^32)
module indication_word_serializer #(
    parameter logic [15:0] MSG_TAG   = 16'hEC01,
    parameter bit          HEADER_EN = 1'b1
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         in_enq__ENA,
    input  logic [127:0] in_enq_v,
    input  logic [15:0]  in_enq_length,
    output logic         in_enq__RDY,
    output logic         out_enq__ENA,
    output logic [31:0]  out_enq_v,
    output logic         out_enq_last,
    input  logic         out_enq__RDY,
    output logic         err_length,
    output logic [31:0]  msg_count
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t           state, state_n;
    logic [3:0][31:0] payload;
    logic [15:0]      len_raw;
    logic [2:0]       len_eff;
    logic [1:0]       idx, idx_n;

    logic [2:0] in_eff;
    logic       xfer, done, accept, zero_msg;

    assign in_eff = (in_enq_length > 16'd4) ? 3'd4 : in_enq_length[2:0];

    // Outputs are driven only from captured registers; nothing from the
    // input side reaches the output word in the same cycle.
    assign out_enq__ENA = (state != IDLE);

    always_comb begin
        out_enq_v    = 32'd0;
        out_enq_last = 1'b0;
        case (state)
            HDR: begin
                out_enq_v    = {MSG_TAG, len_raw};
                out_enq_last = (len_eff == 3'd0);
            end
            DATA: begin
                out_enq_v    = payload[idx];
                out_enq_last = ({1'b0, idx} == (len_eff - 3'd1));
            end
            default: ;
        endcase
    end

    assign xfer        = out_enq__ENA & out_enq__RDY;
    assign done        = xfer & out_enq_last;
    // Accepting on the final transfer lets the next message start with no gap.
    assign in_enq__RDY = (state == IDLE) | done;
    assign accept      = in_enq__ENA & in_enq__RDY;
    // Without a header, an empty message produces no words and completes at once.
    assign zero_msg    = accept & ~HEADER_EN & (in_eff == 3'd0);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            HDR: if (xfer) begin
                idx_n   = 2'd0;
                state_n = (len_eff != 3'd0) ? DATA : IDLE;
            end
            DATA: if (xfer) begin
                if (done) state_n = IDLE;
                else      idx_n   = idx + 2'd1;
            end
            default: ;
        endcase
        // A new message overrides whatever the finishing one chose.
        if (accept) begin
            idx_n = 2'd0;
            if (HEADER_EN)              state_n = HDR;
            else if (in_eff != 3'd0)    state_n = DATA;
            else                        state_n = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            idx        <= 2'd0;
            payload    <= '0;
            len_raw    <= 16'd0;
            len_eff    <= 3'd0;
            err_length <= 1'b0;
            msg_count  <= 32'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (accept) begin
                payload <= in_enq_v;
                len_raw <= in_enq_length;
                len_eff <= in_eff;
                if (in_enq_length > 16'd4) err_length <= 1'b1;
            end
            // A finishing message and an empty one accepted alongside it
            // both count in the same cycle.
            msg_count <= msg_count + {31'd0, done} + {31'd0, zero_msg};
        end
    end

endmodule

// File: tb/tb_indication_word_serializer.sv
module tb_indication_word_serializer;

    logic         CLK = 1'b0;
    logic         nRST = 1'b1;
    // u1: header enabled; u0: header disabled
    logic         ena1 = 0, ena0 = 0;
    logic [127:0] v1 = '0, v0 = '0;
    logic [15:0]  len1 = '0, len0 = '0;
    logic         irdy1, irdy0;
    logic         oena1, oena0;
    logic [31:0]  ov1, ov0;
    logic         olast1, olast0;
    logic         ordy1 = 1, ordy0 = 1;
    logic         err1, err0;
    logic [31:0]  cnt1, cnt0;

    indication_word_serializer #(.MSG_TAG(16'hEC01), .HEADER_EN(1'b1)) u1 (
        .CLK(CLK), .nRST(nRST),
        .in_enq__ENA(ena1), .in_enq_v(v1), .in_enq_length(len1), .in_enq__RDY(irdy1),
        .out_enq__ENA(oena1), .out_enq_v(ov1), .out_enq_last(olast1), .out_enq__RDY(ordy1),
        .err_length(err1), .msg_count(cnt1));

    indication_word_serializer #(.MSG_TAG(16'hEC01), .HEADER_EN(1'b0)) u0 (
        .CLK(CLK), .nRST(nRST),
        .in_enq__ENA(ena0), .in_enq_v(v0), .in_enq_length(len0), .in_enq__RDY(irdy0),
        .out_enq__ENA(oena0), .out_enq_v(ov0), .out_enq_last(olast0), .out_enq__RDY(ordy0),
        .err_length(err0), .msg_count(cnt0));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model state: expected {last, word} streams and counters.
    logic [32:0] q1[$];
    logic [32:0] q0[$];
    int          exp_cnt[2];
    bit          exp_err[2];
    bit          lat_need[2];
    int          lat_cyc[2];
    bit          hv[2];
    logic [31:0] hold_v[2];
    logic        hold_l[2];
    int          mode[2];   // 0: ready high, 1: pattern 1,0,0,1, 2: random
    int          pat[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic rdy_next(input int s);
        logic r;
        case (mode[s])
            0: r = 1'b1;
            1: r = ((pat[s] % 4) == 0) || ((pat[s] % 4) == 3);
            default: r = 1'($urandom_range(0, 1));
        endcase
        return r;
    endfunction

    always @(posedge CLK) begin
        #1;
        ordy1 = rdy_next(1); pat[1]++;
        ordy0 = rdy_next(0); pat[0]++;
    end

    task automatic mon(input int s, input logic ena, input logic rdy, input logic [31:0] v,
                       input logic last, input logic irdy);
        logic [32:0] e;
        if (lat_need[s] && lat_cyc[s] == cyc) begin
            chk($sformatf("latency%0d", s), ena, 1'b1);
            lat_need[s] = 0;
        end
        if (ena) begin
            if (hv[s]) begin
                chk($sformatf("hold_v%0d", s), v, hold_v[s]);
                chk($sformatf("hold_last%0d", s), last, hold_l[s]);
            end
            if (rdy) begin
                if ((s == 1 ? q1.size() : q0.size()) == 0) begin
                    chk($sformatf("extra_word%0d", s), {last, v}, 64'hDEAD);
                end else begin
                    e = (s == 1) ? q1.pop_front() : q0.pop_front();
                    chk($sformatf("word%0d", s), {last, v}, e);
                    if (last) chk($sformatf("in_rdy_on_last%0d", s), irdy, 1'b1);
                end
            end
            hv[s] = !rdy; hold_v[s] = v; hold_l[s] = last;
        end else begin
            if (hv[s]) chk($sformatf("valid_dropped%0d", s), ena, 1'b1);
            hv[s] = 0;
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            mon(1, oena1, ordy1, ov1, olast1, irdy1);
            mon(0, oena0, ordy0, ov0, olast0, irdy0);
        end
    end

    // Caller is at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input int s, input logic [15:0] len, input logic [127:0] v);
        int  t = 0;
        bit  acc = 0;
        int  eff;
        bit  words;
        if (s == 1) begin ena1 = 1; v1 = v; len1 = len; end
        else        begin ena0 = 1; v0 = v; len0 = len; end
        while (!acc && t < 500) begin
            @(negedge CLK);
            if ((s == 1) ? irdy1 : irdy0) acc = 1;
            t++;
        end
        chk($sformatf("accept_timeout%0d", s), acc, 1'b1);
        eff = (len > 16'd4) ? 4 : int'(len);
        if (acc) begin
            if (s == 1) q1.push_back({(eff == 0), 16'hEC01, len});
            for (int i = 0; i < eff; i++) begin
                if (s == 1) q1.push_back({(i == eff - 1), v[32*i +: 32]});
                else        q0.push_back({(i == eff - 1), v[32*i +: 32]});
            end
            exp_cnt[s]++;
            if (len > 16'd4) exp_err[s] = 1;
        end
        words = (s == 1) || (eff > 0);
        @(posedge CLK); #1;
        if (s == 1) ena1 = 0; else ena0 = 0;
        if (acc && words) begin lat_need[s] = 1; lat_cyc[s] = cyc; end
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q0.size() != 0) && t < 3000) begin
            @(negedge CLK); t++;
        end
        chk("drain_q1", q1.size(), 0);
        chk("drain_q0", q0.size(), 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("msg_count1", cnt1, exp_cnt[1]);
        chk("msg_count0", cnt0, exp_cnt[0]);
        chk("err_length1", err1, exp_err[1]);
        chk("err_length0", err0, exp_err[0]);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2 nRST = 0;
        #1;
        chk("rst_in_rdy", {irdy1, irdy0}, 2'b11);
        chk("rst_out_ena", {oena1, oena0}, 2'b00);
        chk("rst_out_v", {ov1, ov0}, 64'd0);
        chk("rst_last", {olast1, olast0}, 2'b00);
        chk("rst_err", {err1, err0}, 2'b00);
        chk("rst_cnt", {cnt1, cnt0}, 64'd0);
        #19 nRST = 1;
        @(posedge CLK); #1;

        // Header, length 3
        send(1, 16'd3, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
        drain();
        // Back to back, no idle between
        send(1, 16'd2, rnd128());
        send(1, 16'd1, rnd128());
        drain();
        // Backpressure pattern
        mode[1] = 1; pat[1] = 0;
        send(1, 16'd4, rnd128());
        drain();
        // Oversized length, then legal ones: err stays set
        mode[1] = 0;
        send(1, 16'd7, rnd128());
        send(1, 16'd2, rnd128());
        drain();

        // No header: empty message, then one word
        send(0, 16'd0, rnd128());
        drain();
        send(0, 16'd1, {96'd0, 32'hDEADBEEF});
        drain();

        // Random traffic on both instances
        mode[1] = 2; mode[0] = 2;
        for (int k = 0; k < 60; k++) begin
            int s = (k % 2);
            send(s, 16'($urandom_range(0, 6)), rnd128());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
        end
        drain();

        // Reset during the second word of a length-4 message
        mode[1] = 0; mode[0] = 0;
        repeat (2) @(posedge CLK); #1;
        send(1, 16'd4, rnd128());
        @(posedge CLK); #2;
        nRST = 0;
        #1;
        chk("midrst_out_ena", oena1, 1'b0);
        chk("midrst_cnt", cnt1, 32'd0);
        chk("midrst_out_v", ov1, 32'd0);
        q1.delete(); q0.delete();
        exp_cnt[1] = 0; exp_cnt[0] = 0; exp_err[1] = 0; exp_err[0] = 0;
        lat_need[1] = 0; lat_need[0] = 0; hv[1] = 0; hv[0] = 0;
        #13 nRST = 1;
        @(negedge CLK);
        chk("post_rst_in_rdy", irdy1, 1'b1);
        chk("post_rst_out_ena", oena1, 1'b0);
        @(posedge CLK); #1;
        send(1, 16'd2, rnd128());
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1);
    end

endmodule
